interrupt_arbiter: RTL and testbench

//  Collects NUM_SRC level request lines (debounced key presses, timers) and latches each rising edge as a pending event.

---
 rtl/intc_pkg.sv | 13 +
 rtl/intc_priority_pick.sv | 41 ++++
 rtl/interrupt_arbiter.sv | 132 +++++++++++++
 tb/tb_interrupt_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared types and default sizing for the interrupt arbiter.
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_ACK = 2'd2
  } intc_state_t;

  localparam int NUM_SRC_DEF      = 4;
  localparam int PULSE_CYCLES_DEF = 7;

endpackage

// File: rtl/intc_priority_pick.sv
// Combinational winner selection over the eligible vector.
// Build option: ROUND_ROBIN_EN -> search begins at 'start' and wraps;
// otherwise the search always begins at index 0 (lowest index wins).
module intc_priority_pick #(
  parameter int NUM_SRC = 4,
  parameter int IDW     = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [IDW-1:0]     start,
  output logic [IDW-1:0]     winner,
  output logic               valid
);

  logic [IDW-1:0] start_eff;

`ifdef ROUND_ROBIN_EN
  assign start_eff = start;
`else
  // Fixed priority ignores the rotating start point.
  logic unused_start;
  assign unused_start = ^start;
  assign start_eff    = '0;
`endif

  // Walk the sources from the farthest to the nearest offset so the
  // nearest eligible one (relative to start_eff) is the last assignment.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      int idx;
      idx = int'(start_eff) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (eligible[idx]) begin
        winner = IDW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: latches rising edges of level requests as pending
// events, grants one unmasked pending source at a time, pulses the CPU
// interrupt line for PULSE_CYCLES and waits for int_ack before regranting.
// Build option: ROUND_ROBIN_EN selects rotating priority (default: fixed,
// lowest index wins).
module interrupt_arbiter
  import intc_pkg::*;
#(
  parameter int NUM_SRC      = NUM_SRC_DEF,
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         req,
  input  logic                       int_en,
  input  logic                       mask_we,
  input  logic [NUM_SRC-1:0]         mask_din,
  input  logic                       int_ack,
  output logic                       interrupt,
  output logic [$clog2(NUM_SRC)-1:0] src_id,
  output logic [NUM_SRC-1:0]         pending,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_SRC);
  localparam int CW  = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PULSE_CYCLES - 1);

  intc_state_t        state_reg, state_next;
  logic [NUM_SRC-1:0] req_q_reg;
  logic [NUM_SRC-1:0] pending_reg, pending_next;
  logic [NUM_SRC-1:0] mask_reg;
  logic [CW-1:0]      cnt_reg;
  logic [IDW-1:0]     src_id_reg;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] clr_vec;
  logic [IDW-1:0]     pick_start;
  logic [IDW-1:0]     pick_winner;
  logic               pick_valid;
  logic               grant;

  assign rise     = req & ~req_q_reg;
  assign eligible = pending_reg & ~mask_reg;
  assign grant    = (state_reg == IDLE) && int_en && pick_valid;

`ifdef ROUND_ROBIN_EN
  // Tracks whether any grant happened since reset, so the first search
  // starts at 0 instead of src_id+1.
  logic rr_armed_reg;

  // Arm rotation on the first grant after reset.
  always_ff @(posedge clk) begin
    if (rst) rr_armed_reg <= 1'b0;
    else if (grant) rr_armed_reg <= 1'b1;
  end

  assign pick_start = !rr_armed_reg ? '0 :
                      (src_id_reg == IDW'(NUM_SRC - 1)) ? '0 : src_id_reg + 1'b1;
`else
  assign pick_start = '0;
`endif

  intc_priority_pick #(
    .NUM_SRC (NUM_SRC),
    .IDW     (IDW)
  ) u_pick (
    .eligible (eligible),
    .start    (pick_start),
    .winner   (pick_winner),
    .valid    (pick_valid)
  );

  // Pending update: clear the granted bit, but a same-cycle rise re-sets it.
  always_comb begin
    clr_vec = '0;
    if (grant) clr_vec[pick_winner] = 1'b1;
    pending_next = (pending_reg & ~clr_vec) | rise;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; an ack during the pulse takes priority over timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (grant) state_next = ASSERT;
      ASSERT: begin
        if (int_ack)                   state_next = IDLE;
        else if (cnt_reg == CNT_LAST)  state_next = WAIT_ACK;
      end
      WAIT_ACK: if (int_ack) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    interrupt = (state_reg == ASSERT);
    busy      = (state_reg != IDLE);
  end

  // Edge detect, pending/mask registers, granted id and pulse counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q_reg   <= '1;
      pending_reg <= '0;
      mask_reg    <= '0;
      src_id_reg  <= '0;
      cnt_reg     <= '0;
    end else begin
      req_q_reg   <= req;
      pending_reg <= pending_next;
      if (mask_we) mask_reg <= mask_din;
      if (grant) begin
        src_id_reg <= pick_winner;
        cnt_reg    <= '0;
      end else if (state_reg == ASSERT) begin
        cnt_reg    <= cnt_reg + 1'b1;
      end
    end
  end

  assign src_id  = src_id_reg;
  assign pending = pending_reg;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Self-checking bench for interrupt_arbiter (NUM_SRC=4, PULSE_CYCLES=7).
// Table-driven per-cycle vectors plus hand-written corner sequences; a
// scoreboard queue holds expected src_id values for each interrupt rise.
module tb_interrupt_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       int_en;
  logic       mask_we;
  logic [3:0] mask_din;
  logic       int_ack;
  logic       interrupt;
  logic [1:0] src_id;
  logic [3:0] pending;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] exp_q[$];
  logic       prev_int = 1'b0;

  typedef struct {
    logic [3:0] req;
    logic       en;
    logic       we;
    logic [3:0] din;
    logic       ack;
    logic       push;
    logic [1:0] pid;
    logic       e_int;
    logic [1:0] e_id;
    logic [3:0] e_pend;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  interrupt_arbiter #(.NUM_SRC(4), .PULSE_CYCLES(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .int_en    (int_en),
    .mask_we   (mask_we),
    .mask_din  (mask_din),
    .int_ack   (int_ack),
    .interrupt (interrupt),
    .src_id    (src_id),
    .pending   (pending),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_int, input logic [1:0] e_id,
                            input logic [3:0] e_pend, input logic e_busy);
    check({tag, "_int"},  int'(interrupt), int'(e_int));
    check({tag, "_id"},   int'(src_id),    int'(e_id));
    check({tag, "_pend"}, int'(pending),   int'(e_pend));
    check({tag, "_busy"}, int'(busy),      int'(e_busy));
    $display("%s: int=%0d id=%0d pend=%b busy=%0d", tag, interrupt, src_id, pending, busy);
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic en, input logic we,
                              input logic [3:0] din, input logic ack, input logic push,
                              input logic [1:0] pid, input logic ei, input logic [1:0] eid,
                              input logic [3:0] ep, input logic eb);
    vec_t v;
    v.req = r; v.en = en; v.we = we; v.din = din; v.ack = ack;
    v.push = push; v.pid = pid;
    v.e_int = ei; v.e_id = eid; v.e_pend = ep; v.e_busy = eb;
    return v;
  endfunction

  // Scoreboard: every rising edge of interrupt must match the next expected id.
  always @(posedge clk) begin
    #1;
    if (interrupt && !prev_int) begin
      if (exp_q.size() == 0) check("sb_unexpected_grant", 1, 0);
      else check("sb_src_id", int'(src_id), int'(exp_q.pop_front()));
    end
    prev_int <= interrupt;
  end

  initial begin
    // Test 1: single source, full 7-cycle pulse, then ack in WAIT_ACK.
    //             req     en we din     ack push pid  int id pend   busy
    vecs.push_back(mk(4'b0000,1,0,4'b0000,0, 0,2'd0, 0,2'd0,4'b0000,0));
    vecs.push_back(mk(4'b0001,1,0,4'b0000,0, 1,2'd0, 0,2'd0,4'b0001,0));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(4'b0001,1,0,4'b0000,0, 0,2'd0, 1,2'd0,4'b0000,1));
    vecs.push_back(mk(4'b0001,1,0,4'b0000,0, 0,2'd0, 0,2'd0,4'b0000,1));
    vecs.push_back(mk(4'b0001,1,0,4'b0000,1, 0,2'd0, 0,2'd0,4'b0000,0));
    // Tests 2+5: bits 1,2 rise together; ack on third pulse cycle.
    vecs.push_back(mk(4'b0111,1,0,4'b0000,0, 1,2'd1, 0,2'd0,4'b0110,0));
    vecs.push_back(mk(4'b0111,1,0,4'b0000,0, 1,2'd2, 1,2'd1,4'b0100,1));
    vecs.push_back(mk(4'b0111,1,0,4'b0000,0, 0,2'd0, 1,2'd1,4'b0100,1));
    vecs.push_back(mk(4'b0111,1,0,4'b0000,0, 0,2'd0, 1,2'd1,4'b0100,1));
    vecs.push_back(mk(4'b0111,1,0,4'b0000,1, 0,2'd0, 0,2'd1,4'b0100,0));
    vecs.push_back(mk(4'b0111,1,0,4'b0000,0, 0,2'd0, 1,2'd2,4'b0000,1));
    vecs.push_back(mk(4'b0111,1,0,4'b0000,1, 0,2'd0, 0,2'd2,4'b0000,0));
    // Test 3: masked source latches pending but is not granted until unmasked.
    vecs.push_back(mk(4'b0111,1,1,4'b1000,0, 0,2'd0, 0,2'd2,4'b0000,0));
    vecs.push_back(mk(4'b1111,1,0,4'b0000,0, 0,2'd0, 0,2'd2,4'b1000,0));
    vecs.push_back(mk(4'b1111,1,0,4'b0000,0, 0,2'd0, 0,2'd2,4'b1000,0));
    vecs.push_back(mk(4'b1111,1,1,4'b0000,0, 1,2'd3, 0,2'd2,4'b1000,0));
    vecs.push_back(mk(4'b1111,1,0,4'b0000,0, 0,2'd0, 1,2'd3,4'b0000,1));
    vecs.push_back(mk(4'b1111,1,0,4'b0000,1, 0,2'd0, 0,2'd3,4'b0000,0));
    // Test 4 setup: make source 1 pending with interrupts disabled.
    vecs.push_back(mk(4'b1101,0,0,4'b0000,0, 0,2'd0, 0,2'd3,4'b0000,0));
    vecs.push_back(mk(4'b1111,0,0,4'b0000,0, 0,2'd0, 0,2'd3,4'b0010,0));

    // Reset with req low; outputs must be at reset values.
    rst = 1'b1; req = 4'b0000; int_en = 1'b0; mask_we = 1'b0;
    mask_din = 4'b0000; int_ack = 1'b0;
    step();
    step();
    check_outs("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      req = vecs[i].req; int_en = vecs[i].en; mask_we = vecs[i].we;
      mask_din = vecs[i].din; int_ack = vecs[i].ack;
      if (vecs[i].push) exp_q.push_back(vecs[i].pid);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].e_int, vecs[i].e_id,
                 vecs[i].e_pend, vecs[i].e_busy);
    end
    mask_we = 1'b0; int_ack = 1'b0;

    // Test 4: int_en low keeps pending source waiting for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      step();
      check_outs($sformatf("noen%0d", i), 1'b0, 2'd3, 4'b0010, 1'b0);
    end
    int_en = 1'b1;
    exp_q.push_back(2'd1);
    step();
    check_outs("en_grant", 1'b1, 2'd1, 4'b0000, 1'b1);
    // Dropping int_en mid-pulse must not abort the grant.
    int_en = 1'b0;
    step();
    check_outs("en_drop", 1'b1, 2'd1, 4'b0000, 1'b1);
    int_ack = 1'b1;
    step();
    check_outs("en_ack", 1'b0, 2'd1, 4'b0000, 1'b0);
    int_ack = 1'b0; int_en = 1'b1;

    // Test 6: reset during the fourth pulse cycle drops everything.
    req = 4'b1011;
    step();
    check_outs("rst_pre0", 1'b0, 2'd1, 4'b0000, 1'b0);
    req = 4'b1111;
    exp_q.push_back(2'd2);
    step();
    check_outs("rst_pre1", 1'b0, 2'd1, 4'b0100, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_outs($sformatf("rst_pulse%0d", i), 1'b1, 2'd2, 4'b0000, 1'b1);
    end
    rst = 1'b1;
    step();
    check_outs("rst_mid", 1'b0, 2'd0, 4'b0000, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_outs($sformatf("rst_hold%0d", i), 1'b0, 2'd0, 4'b0000, 1'b0);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
